sm_clk_ctrl: RTL and testbench
==============================

# sm_clk_ctrl

Parametrised clock controller for the schoolMIPS board top, succeeding the simple tunable clock divider. It derives the CPU clock `clkOut` from the board clock with a power-of-two divide ratio that changes glitch-free only at period boundaries. It adds halt, free-run and single-step modes, a debounced step button, a per-edge `tick` strobe and a rising-edge counter. All inputs are asynchronous board switches/buttons and are synchronised internally.

## Interface
- `SHIFT`, 16: base exponent; half-period = 2^(SHIFT+devide) clkIn cycles
- `DIV_W`, 4: width of `devide`
- `CNT_W`, 32: half-period counter width; exponent saturates at CNT_W-1
- `SYNC_STAGES`, 2: synchroniser depth for all inputs (≥2)
- `DEB_W`, 16: step debounce counter width; stable time 2^DEB_W cycles
- `clkIn`  in  1  board clock, sole clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `devide`  in  DIV_W  divide select, async
- `mode`  in  2  00 halt, 01 run, 10 step, 11 treated as run; async
- `step`  in  1  step button, async, bouncing
- `clkOut`  out  1  generated clock, registered
- `tick`  out  1  one-clkIn-cycle pulse, coincident with each clkOut rising edge
- `busy`  out  1  high while a single-step period is in progress
- `edgeCount`  out  32  number of clkOut rising edges since reset, wraps

## Operation
- `devide`, `mode`, `step` each pass through SYNC_STAGES flops (sub-module).
- Step debounce: synced step must hold a new level for 2^DEB_W consecutive cycles before debounced level changes; debounced 0→1 = step request (one per press).
- Exponent E = min(SHIFT + devSel, CNT_W-1); H = 2^E. devSel is latched from synced `devide` only when a new period starts (clkOut 0→1) and on HALT entry; mid-period changes never shorten/lengthen the current period.
- Half-period counter loads H-1, counts down; at 0 clkOut toggles and counter reloads.
- FSM states: HALT, RUN_HI, RUN_LO, STEP_HI, STEP_LO.
- HALT: clkOut=0, counter idle. Synced mode run → RUN_HI next cycle. Synced mode step and step request → STEP_HI.
- RUN_HI → RUN_LO after H cycles. RUN_LO → after H cycles: RUN_HI if mode still run, else HALT (current period always completes; clkOut never truncated).
- STEP_HI → STEP_LO after H cycles; STEP_LO → HALT after H cycles. `busy`=1 in STEP_HI/STEP_LO.
- Step requests in RUN_*, STEP_* or with mode≠step are discarded, not queued.
- Mode changes during STEP_* take effect only after returning to HALT.
- Entering RUN_HI or STEP_HI: clkOut←1, tick←1 for one cycle, edgeCount+1 (mod 2^32).

## Timing
- Reset (async assert): clkOut=0, tick=0, busy=0, edgeCount=0, state HALT, devSel=0, debounced step=0, synchroniser flops 0.
- Reset released mid-period: no partial clkOut pulse; first edge follows normal HALT exit.
- Mode latency: synced value visible SYNC_STAGES cycles after pin change; clkOut rises on the next clkIn edge (SYNC_STAGES+1 total).
- Step latency: SYNC_STAGES + 2^DEB_W + 1 cycles from clean press to clkOut rising.
- Duty cycle exactly 50%; period 2H clkIn cycles; `clkOut` is a flop output (no combinational muxing of clocks).

## Structure
- Shared package: mode encodings (MODE_HALT/RUN/STEP), FSM state encodings, defaults for SHIFT/DIV_W/CNT_W.
- One sub-module `sm_sync` (parametrised WIDTH, STAGES multi-flop synchroniser with async active-low reset), instantiated for devide, mode, step.
- Debounce counter, half-period counter, FSM and edgeCount inline in sm_clk_ctrl.

## Test plan
Bench parameters: SHIFT=0, DIV_W=4, CNT_W=8, SYNC_STAGES=2, DEB_W=2.
- Reset, mode=01, devide=1 → clkOut rises 3 cycles after mode change; period 4 cycles, 2 high/2 low; tick pulses 1 cycle per rise; edgeCount 1,2,3…
- In run with devide=1, change devide to 3 mid-high-half → current period stays 4 cycles, next period 16 cycles (8/8).
- Run→halt (mode=00) during high half → low half completes fully, then clkOut stays 0, edgeCount frozen.
- mode=10, step pressed with 3-cycle bounce then held → exactly one 2H-cycle pulse, busy high for 2H cycles, edgeCount+1; second press during busy → ignored.
- Press shorter than 4 cycles → no step; devide=15 with CNT_W=8 → exponent saturates at 7, half-period 128.
- Assert rst_n low mid-high-half → clkOut, tick, busy, edgeCount 0 immediately (asynchronously); after release with mode=00 clkOut stays 0.

Source files
------------

// File: rtl/sm_clk_ctrl_pkg.sv
// Shared definitions for the schoolMIPS clock controller: mode encodings,
// FSM states, default parameters and small decode helpers.
package sm_clk_ctrl_pkg;

  // Board switch encodings for the mode input
  localparam logic [1:0] MODE_HALT    = 2'b00;
  localparam logic [1:0] MODE_RUN     = 2'b01;
  localparam logic [1:0] MODE_STEP    = 2'b10;
  localparam logic [1:0] MODE_RUN_ALT = 2'b11;

  // Default configuration for the board build
  localparam int DEF_SHIFT       = 16;
  localparam int DEF_DIV_W       = 4;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEB_W       = 16;
  localparam int EDGE_W          = 32;

  // Controller states: halted, free-running halves, single-step halves
  typedef enum logic [2:0] {
    HALT,
    RUN_HI,
    RUN_LO,
    STEP_HI,
    STEP_LO
  } clkState_t;

  // The unused encoding 11 behaves exactly like run
  function automatic logic isRunMode(input logic [1:0] m);
    return (m == MODE_RUN) || (m == MODE_RUN_ALT);
  endfunction

  // Half-period exponent, clamped so 2^exp still fits the counter
  function automatic int satExp(input int base, input int sel, input int maxExp);
    int e;
    e = base + sel;
    if (e > maxExp) e = maxExp;
    return e;
  endfunction

endpackage

// File: rtl/sm_sync.sv
// Multi-flop synchroniser for asynchronous board inputs. Every stage clears
// on reset so the controller starts from a known halted, unpressed view.
module sm_sync
  import sm_clk_ctrl_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [STAGES];

  // Shift the raw input through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/sm_clk_ctrl.sv
// CPU clock controller: divides clkIn by a power of two, with halt, run and
// debounced single-step modes. clkOut is a plain flop output and the divide
// ratio is only picked up at period boundaries, so edges are never glitched.
module sm_clk_ctrl
  import sm_clk_ctrl_pkg::*;
#(
  parameter int SHIFT       = DEF_SHIFT,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_W       = DEF_DEB_W
) (
  input  logic              clkIn,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  devide,
  input  logic [1:0]        mode,
  input  logic              step,
  output logic              clkOut,
  output logic              tick,
  output logic              busy,
  output logic [EDGE_W-1:0] edgeCount
);

  logic [DIV_W-1:0] devSync;
  logic [1:0]       modeSync;
  logic             stepSync;

  sm_sync #(.WIDTH(DIV_W), .STAGES(SYNC_STAGES)) uDevSync (
    .clk   (clkIn),
    .rst_n (rst_n),
    .d     (devide),
    .q     (devSync)
  );

  sm_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) uModeSync (
    .clk   (clkIn),
    .rst_n (rst_n),
    .d     (mode),
    .q     (modeSync)
  );

  sm_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) uStepSync (
    .clk   (clkIn),
    .rst_n (rst_n),
    .d     (step),
    .q     (stepSync)
  );

  // Reload value H-1 for a given divide select, with saturated exponent
  function automatic logic [CNT_W-1:0] halfLoad(input logic [DIV_W-1:0] sel);
    logic [CNT_W-1:0] span;
    span = CNT_W'(1) << satExp(SHIFT, int'(sel), CNT_W - 1);
    return span - CNT_W'(1);
  endfunction

  logic [DEB_W-1:0] debCnt;
  logic             stepDeb;
  logic             stepReq;

  // Debounce: a new step level must persist 2^DEB_W cycles; a 0->1 change
  // of the filtered level raises a one-cycle step request
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      debCnt  <= '0;
      stepDeb <= 1'b0;
      stepReq <= 1'b0;
    end else begin
      stepReq <= 1'b0;
      if (stepSync == stepDeb) begin
        debCnt <= '0;
      end else if (&debCnt) begin
        debCnt  <= '0;
        stepDeb <= stepSync;
        stepReq <= stepSync;
      end else begin
        debCnt <= debCnt + DEB_W'(1);
      end
    end
  end

  clkState_t        state;
  logic [CNT_W-1:0] halfCnt;
  logic [DIV_W-1:0] devSel;
  logic             halfDone;
  logic             startRun;
  logic             startStep;

  // Decide when a fresh clkOut period begins (rising edge this cycle)
  always_comb begin
    halfDone  = (halfCnt == '0);
    startRun  = isRunMode(modeSync) &&
                ((state == HALT) || ((state == RUN_LO) && halfDone));
    startStep = (state == HALT) && (modeSync == MODE_STEP) && stepReq;
  end

  // Clock FSM with half-period counter, registered clkOut/tick/busy and the
  // rising-edge counter
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HALT;
      halfCnt   <= '0;
      devSel    <= '0;
      clkOut    <= 1'b0;
      tick      <= 1'b0;
      busy      <= 1'b0;
      edgeCount <= '0;
    end else begin
      tick <= 1'b0;
      if (startRun || startStep) begin
        state     <= startRun ? RUN_HI : STEP_HI;
        busy      <= startStep;
        clkOut    <= 1'b1;
        tick      <= 1'b1;
        edgeCount <= edgeCount + EDGE_W'(1);
        devSel    <= devSync;
        halfCnt   <= halfLoad(devSync);
      end else begin
        case (state)
          HALT: begin
            clkOut  <= 1'b0;
            halfCnt <= '0;
          end
          RUN_HI, STEP_HI: begin
            if (halfDone) begin
              state   <= (state == RUN_HI) ? RUN_LO : STEP_LO;
              clkOut  <= 1'b0;
              halfCnt <= halfLoad(devSel);
            end else begin
              halfCnt <= halfCnt - CNT_W'(1);
            end
          end
          RUN_LO, STEP_LO: begin
            if (halfDone) begin
              state   <= HALT;
              busy    <= 1'b0;
              devSel  <= devSync;
              halfCnt <= '0;
            end else begin
              halfCnt <= halfCnt - CNT_W'(1);
            end
          end
          default: begin
            state   <= HALT;
            clkOut  <= 1'b0;
            busy    <= 1'b0;
            halfCnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Directed bench for sm_clk_ctrl with small parameters so every period,
// debounce window and saturation case can be walked cycle by cycle.
module tb_sm_clk_ctrl;

  logic        clkIn;
  logic        rst_n;
  logic [3:0]  devide;
  logic [1:0]  mode;
  logic        step;
  logic        clkOut;
  logic        tick;
  logic        busy;
  logic [31:0] edgeCount;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  sm_clk_ctrl #(
    .SHIFT       (0),
    .DIV_W       (4),
    .CNT_W       (8),
    .SYNC_STAGES (2),
    .DEB_W       (2)
  ) dut (
    .clkIn     (clkIn),
    .rst_n     (rst_n),
    .devide    (devide),
    .mode      (mode),
    .step      (step),
    .clkOut    (clkOut),
    .tick      (tick),
    .busy      (busy),
    .edgeCount (edgeCount)
  );

  // Free-running board clock
  initial begin
    clkIn = 1'b0;
    forever #5 clkIn = ~clkIn;
  end

  // Drive all board inputs at once
  task automatic applyStimulus(input logic [1:0] m, input logic [3:0] d, input logic s);
    mode   = m;
    devide = d;
    step   = s;
  endtask

  // Advance n clkIn rising edges, landing 1 ns after the last one
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clkIn);
    #1;
  endtask

  // One comparison against a hand-computed value
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence
  initial begin
    rst_n = 1'b0;
    applyStimulus(2'b00, 4'd0, 1'b0);
    waitCycles(3);
    checkOutput("rstClkOut", 32'(clkOut), 32'd0);
    checkOutput("rstTick",   32'(tick),   32'd0);
    checkOutput("rstBusy",   32'(busy),   32'd0);
    checkOutput("rstEdges",  edgeCount,   32'd0);
    rst_n = 1'b1;
    waitCycles(2);
    checkOutput("haltIdle", 32'(clkOut), 32'd0);

    // Run with devide=1: H=2, first rise 3 edges after the mode change
    applyStimulus(2'b01, 4'd1, 1'b0);
    waitCycles(2);
    checkOutput("runLatency", 32'(clkOut), 32'd0);
    waitCycles(1);
    checkOutput("run1Rise",  32'(clkOut), 32'd1);
    checkOutput("run1Tick",  32'(tick),   32'd1);
    checkOutput("run1Edges", edgeCount,   32'd1);
    waitCycles(1);
    checkOutput("run1High2", 32'(clkOut), 32'd1);
    checkOutput("run1TickOff", 32'(tick), 32'd0);
    waitCycles(1);
    checkOutput("run1Low1", 32'(clkOut), 32'd0);
    waitCycles(1);
    checkOutput("run1Low2", 32'(clkOut), 32'd0);
    waitCycles(1);
    checkOutput("run2Rise",  32'(clkOut), 32'd1);
    checkOutput("run2Tick",  32'(tick),   32'd1);
    checkOutput("run2Edges", edgeCount,   32'd2);

    // devide 1 -> 3 in the first high cycle: this period keeps H=2
    applyStimulus(2'b01, 4'd3, 1'b0);
    waitCycles(2);
    checkOutput("keepLow1", 32'(clkOut), 32'd0);
    waitCycles(1);
    checkOutput("keepLow2", 32'(clkOut), 32'd0);
    waitCycles(1);
    checkOutput("run3Rise",  32'(clkOut), 32'd1);
    checkOutput("run3Edges", edgeCount,   32'd3);
    waitCycles(7);
    checkOutput("newHighEnd", 32'(clkOut), 32'd1);
    waitCycles(1);
    checkOutput("newLowStart", 32'(clkOut), 32'd0);
    waitCycles(7);
    checkOutput("newLowEnd", 32'(clkOut), 32'd0);
    waitCycles(1);
    checkOutput("run4Rise",  32'(clkOut), 32'd1);
    checkOutput("run4Tick",  32'(tick),   32'd1);
    checkOutput("run4Edges", edgeCount,   32'd4);

    // Halt during the high half: high and low halves both complete
    waitCycles(1);
    applyStimulus(2'b00, 4'd3, 1'b0);
    waitCycles(6);
    checkOutput("haltKeepHigh", 32'(clkOut), 32'd1);
    waitCycles(1);
    checkOutput("haltLowStart", 32'(clkOut), 32'd0);
    waitCycles(7);
    checkOutput("haltLowEnd", 32'(clkOut), 32'd0);
    checkOutput("haltLowEdges", edgeCount, 32'd4);
    waitCycles(9);
    checkOutput("haltedClk",   32'(clkOut), 32'd0);
    checkOutput("haltedEdges", edgeCount,   32'd4);

    // Step mode with H=8; press with a 3-cycle bounce then held
    applyStimulus(2'b10, 4'd3, 1'b0);
    waitCycles(4);
    step = 1'b1;
    waitCycles(1);
    step = 1'b0;
    waitCycles(1);
    step = 1'b1;
    waitCycles(6);
    checkOutput("stepWait",     32'(clkOut), 32'd0);
    checkOutput("stepWaitBusy", 32'(busy),   32'd0);
    waitCycles(1);
    checkOutput("stepRise",  32'(clkOut), 32'd1);
    checkOutput("stepBusy",  32'(busy),   32'd1);
    checkOutput("stepTick",  32'(tick),   32'd1);
    checkOutput("stepEdges", edgeCount,   32'd5);
    waitCycles(1);
    step = 1'b0;
    waitCycles(6);
    step = 1'b1;
    waitCycles(8);
    checkOutput("stepBusyEnd", 32'(busy),   32'd1);
    checkOutput("stepLowEnd",  32'(clkOut), 32'd0);
    checkOutput("stepMidEdges", edgeCount,  32'd5);
    waitCycles(1);
    checkOutput("stepBusyOff", 32'(busy),   32'd0);
    checkOutput("stepHaltClk", 32'(clkOut), 32'd0);
    waitCycles(5);
    checkOutput("secondPressIgnored", edgeCount, 32'd5);
    checkOutput("secondPressClk", 32'(clkOut), 32'd0);
    step = 1'b0;
    waitCycles(8);

    // Press lasting only 3 cycles never passes the debounce window
    step = 1'b1;
    waitCycles(3);
    step = 1'b0;
    waitCycles(12);
    checkOutput("shortPressEdges", edgeCount,   32'd5);
    checkOutput("shortPressClk",   32'(clkOut), 32'd0);
    checkOutput("shortPressBusy",  32'(busy),   32'd0);

    // devide=15 saturates the exponent at 7: half-period 128
    applyStimulus(2'b01, 4'd15, 1'b0);
    waitCycles(3);
    checkOutput("satRise",  32'(clkOut), 32'd1);
    checkOutput("satEdges", edgeCount,   32'd6);
    waitCycles(127);
    checkOutput("satHighEnd", 32'(clkOut), 32'd1);
    waitCycles(1);
    checkOutput("satLowStart", 32'(clkOut), 32'd0);
    waitCycles(128);
    checkOutput("satRise2",  32'(clkOut), 32'd1);
    checkOutput("satEdges2", edgeCount,   32'd7);

    // Asynchronous reset in the middle of a high half
    waitCycles(5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstClk",   32'(clkOut), 32'd0);
    checkOutput("asyncRstTick",  32'(tick),   32'd0);
    checkOutput("asyncRstBusy",  32'(busy),   32'd0);
    checkOutput("asyncRstEdges", edgeCount,   32'd0);
    applyStimulus(2'b00, 4'd15, 1'b0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(10);
    checkOutput("postRstClk",   32'(clkOut), 32'd0);
    checkOutput("postRstEdges", edgeCount,   32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
